// File: rtl/ifp_stage_pkg.sv
// Shared fetch-stage types and widths.
package ifp_stage_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } ifp_state_t;

endpackage

// File: rtl/ifp_skid_buf.sv
// One-entry {pc, instr} holding register for responses that arrive while stalled.
// Clear wins over load; unload only empties the entry, the data stays readable.
module ifp_skid_buf
  import ifp_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [XLEN-1:0]    load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic [XLEN-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifp_stage.sv
// Fetch PC stage: single-outstanding imem requests, response to IFR register,
// stalled responses parked in a skid entry, redirects cancel in-flight fetches.
module ifp_stage
  import ifp_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_IFP,
  input  logic               branch_taken_IFP,
  input  logic [XLEN-1:0]    branch_target_IFP,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [XLEN-1:0]    pc_IFR,
  output logic [INSTR_W-1:0] instr_IFR,
  output logic               valid_IFR
);

  ifp_state_t        state, state_nxt;
  logic [XLEN-1:0]   pc, req_pc;
  logic              fire, rsp_take, deliver, skid_load, skid_unload;
  logic [XLEN-1:0]   skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic              skid_valid;

  // Gated by the hazard inputs so a grant can never coincide with a redirect.
  assign imem_req  = (state == S_REQ) && !stall_IFP && !branch_taken_IFP;
  assign imem_addr = pc;

  assign fire        = imem_req && imem_gnt;
  assign rsp_take    = (state == S_WAIT) && imem_rvalid && !branch_taken_IFP;
  assign deliver     = rsp_take && !stall_IFP;
  assign skid_load   = rsp_take && stall_IFP;
  assign skid_unload = (state == S_HOLD) && skid_valid && !stall_IFP && !branch_taken_IFP;

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (fire) state_nxt = S_WAIT;
      S_WAIT: begin
        if (branch_taken_IFP)  state_nxt = S_DROP;
        else if (imem_rvalid)  state_nxt = stall_IFP ? S_HOLD : S_REQ;
      end
      S_HOLD: if (branch_taken_IFP || !stall_IFP) state_nxt = S_REQ;
      S_DROP: if (!branch_taken_IFP && imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (branch_taken_IFP) begin
        pc <= branch_target_IFP & ~64'h3;
      end else if (fire) begin
        req_pc <= pc;
        pc     <= pc + 64'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_IFR    <= '0;
      instr_IFR <= '0;
      valid_IFR <= 1'b0;
    end else if (branch_taken_IFP) begin
      valid_IFR <= 1'b0;
    end else if (stall_IFP) begin
      valid_IFR <= valid_IFR;
    end else if (deliver) begin
      pc_IFR    <= req_pc;
      instr_IFR <= imem_rdata;
      valid_IFR <= 1'b1;
    end else if (skid_unload) begin
      pc_IFR    <= skid_pc;
      instr_IFR <= skid_instr;
      valid_IFR <= 1'b1;
    end else begin
      valid_IFR <= 1'b0;
    end
  end

  ifp_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (branch_taken_IFP),
    .load_pc    (req_pc),
    .load_instr (imem_rdata),
    .pc         (skid_pc),
    .instr      (skid_instr),
    .valid      (skid_valid)
  );

endmodule

// File: tb/tb_ifp_stage.sv
// Directed vectors for ifp_stage: inputs change 1 ns after the rising edge, outputs checked 1 ns later.
module tb_ifp_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_IFP;
  logic        branch_taken_IFP;
  logic [63:0] branch_target_IFP;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] pc_IFR;
  logic [31:0] instr_IFR;
  logic        valid_IFR;

  int vectors = 0;
  int miscompares = 0;

  ifp_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall_IFP         (stall_IFP),
    .branch_taken_IFP  (branch_taken_IFP),
    .branch_target_IFP (branch_target_IFP),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_gnt          (imem_gnt),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .pc_IFR            (pc_IFR),
    .instr_IFR         (instr_IFR),
    .valid_IFR         (valid_IFR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall_IFP = 1'b0;
    branch_taken_IFP = 1'b0;
    branch_target_IFP = '0;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;

    tick(); #1;
    chk("rst_valid", {63'd0, valid_IFR}, 64'd0);
    chk("rst_pc_ifr", pc_IFR, 64'd0);
    chk("rst_instr", {32'd0, instr_IFR}, 64'd0);
    chk("rst_addr", imem_addr, 64'h8000_0000);

    // cycle 0: release reset, first request granted
    tick(); rst = 1'b0; #1;
    chk("c0_req", {63'd0, imem_req}, 64'd1);
    chk("c0_addr", imem_addr, 64'h8000_0000);
    // cycle 1: response
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; #1;
    chk("c1_req", {63'd0, imem_req}, 64'd0);
    // cycle 2: delivered, next request
    tick(); imem_rvalid = 1'b0; #1;
    chk("c2_valid", {63'd0, valid_IFR}, 64'd1);
    chk("c2_pc_ifr", pc_IFR, 64'h8000_0000);
    chk("c2_instr", {32'd0, instr_IFR}, 64'h13);
    chk("c2_req", {63'd0, imem_req}, 64'd1);
    chk("c2_addr", imem_addr, 64'h8000_0004);

    // cycle 3: response under stall (stall 3..5)
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall_IFP = 1'b1; #1;
    chk("c3_valid", {63'd0, valid_IFR}, 64'd0);
    tick(); imem_rvalid = 1'b0; #1;
    chk("c4_valid", {63'd0, valid_IFR}, 64'd0);
    chk("c4_req", {63'd0, imem_req}, 64'd0);
    tick(); #1;
    chk("c5_valid", {63'd0, valid_IFR}, 64'd0);
    chk("c5_req", {63'd0, imem_req}, 64'd0);
    // cycle 6: stall released in S_HOLD
    tick(); stall_IFP = 1'b0; #1;
    chk("c6_req", {63'd0, imem_req}, 64'd0);
    chk("c6_valid", {63'd0, valid_IFR}, 64'd0);
    // cycle 7: skid entry delivered, request for 0x8000_0008 granted
    tick(); #1;
    chk("c7_valid", {63'd0, valid_IFR}, 64'd1);
    chk("c7_instr", {32'd0, instr_IFR}, 64'hDEAD_BEEF);
    chk("c7_pc_ifr", pc_IFR, 64'h8000_0004);
    chk("c7_addr", imem_addr, 64'h8000_0008);

    // cycle 8: redirect while waiting
    tick(); branch_taken_IFP = 1'b1; branch_target_IFP = 64'h8000_0102; #1;
    chk("c8_req", {63'd0, imem_req}, 64'd0);
    chk("c8_valid", {63'd0, valid_IFR}, 64'd0);
    // cycle 9: stale response in S_DROP
    tick(); branch_taken_IFP = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;
    chk("c9_req", {63'd0, imem_req}, 64'd0);
    chk("c9_addr", imem_addr, 64'h8000_0100);
    // cycle 10: fetch at aligned target, stale data not delivered
    tick(); imem_rvalid = 1'b0; #1;
    chk("c10_valid", {63'd0, valid_IFR}, 64'd0);
    chk("c10_req", {63'd0, imem_req}, 64'd1);
    chk("c10_addr", imem_addr, 64'h8000_0100);

    // cycle 11: response under stall -> S_HOLD
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; stall_IFP = 1'b1; #1;
    // cycle 12: redirect + stall in S_HOLD
    tick(); imem_rvalid = 1'b0; branch_taken_IFP = 1'b1; branch_target_IFP = 64'h8000_0200; #1;
    chk("c12_valid", {63'd0, valid_IFR}, 64'd0);
    // cycle 13: still stalled
    tick(); branch_taken_IFP = 1'b0; #1;
    chk("c13_valid", {63'd0, valid_IFR}, 64'd0);
    chk("c13_req", {63'd0, imem_req}, 64'd0);
    chk("c13_addr", imem_addr, 64'h8000_0200);
    // cycle 14: stall released, skid entry must be gone
    tick(); stall_IFP = 1'b0; #1;
    chk("c14_req", {63'd0, imem_req}, 64'd1);
    chk("c14_addr", imem_addr, 64'h8000_0200);
    // cycle 15: in S_WAIT, redirect to top of address space
    tick(); #1;
    chk("c15_valid", {63'd0, valid_IFR}, 64'd0);
    branch_taken_IFP = 1'b1; branch_target_IFP = 64'hFFFF_FFFF_FFFF_FFFF;
    // cycle 16: stale response in S_DROP
    tick(); branch_taken_IFP = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555; #1;
    chk("c16_req", {63'd0, imem_req}, 64'd0);
    // cycle 17: request at 0xFFFF_FFFF_FFFF_FFFC
    tick(); imem_rvalid = 1'b0; #1;
    chk("c17_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("c17_valid", {63'd0, valid_IFR}, 64'd0);
    // cycle 18: pc wrapped
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0000_0022; #1;
    chk("c18_addr", imem_addr, 64'h0);
    // cycle 19: delivered, request for 0x0 granted
    tick(); imem_rvalid = 1'b0; #1;
    chk("c19_valid", {63'd0, valid_IFR}, 64'd1);
    chk("c19_pc_ifr", pc_IFR, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("c19_instr", {32'd0, instr_IFR}, 64'h22);
    chk("c19_req", {63'd0, imem_req}, 64'd1);

    // cycle 20: reset while in S_WAIT
    tick(); rst = 1'b1; #1;
    chk("c20_valid", {63'd0, valid_IFR}, 64'd0);
    chk("c20_pc_ifr", pc_IFR, 64'd0);
    chk("c20_instr", {32'd0, instr_IFR}, 64'd0);
    chk("c20_addr", imem_addr, 64'h8000_0000);
    // cycle 21: release with the abandoned response arriving late
    tick(); rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD; #1;
    chk("c21_req", {63'd0, imem_req}, 64'd1);
    chk("c21_addr", imem_addr, 64'h8000_0000);
    // cycle 22: late data must not appear; real response now
    tick(); imem_rdata = 32'h0000_0044; #1;
    chk("c22_valid", {63'd0, valid_IFR}, 64'd0);
    chk("c22_instr", {32'd0, instr_IFR}, 64'd0);
    // cycle 23
    tick(); imem_rvalid = 1'b0; #1;
    chk("c23_valid", {63'd0, valid_IFR}, 64'd1);
    chk("c23_pc_ifr", pc_IFR, 64'h8000_0000);
    chk("c23_instr", {32'd0, instr_IFR}, 64'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
